// File: rtl/axis_demux_skid.sv
// Output stage of axis_demux: an output register backed by a temp register.
// Each entry carries the beat payload and its own destination index, so a
// frame still draining to one port can be followed by a frame to another port.
module axis_demux_skid #(
  parameter int M_COUNT   = 4,
  parameter int PAYLOAD_W = 8,
  parameter int SEL_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PAYLOAD_W-1:0] int_data,
  input  logic [SEL_W-1:0]     int_sel,
  input  logic                 int_valid,
  output logic                 ready_int_early,
  input  logic [M_COUNT-1:0]   m_tready,
  output logic [M_COUNT-1:0]   m_tvalid,
  output logic [PAYLOAD_W-1:0] out_data
);

  logic                 out_valid, temp_valid, ready_int_reg;
  logic [SEL_W-1:0]     out_sel, temp_sel;
  logic [PAYLOAD_W-1:0] temp_data;
  logic                 sel_ready;

  // Ready of whichever port the held output beat is addressed to.
  assign sel_ready = m_tready[out_sel];

  // Upstream may send next cycle if the output drains now, or if there is
  // still room for one more beat even when the output stays stalled.
  assign ready_int_early = sel_ready || (!temp_valid && (!out_valid || !int_valid));

  // One-hot valid: only the lane matching the held beat's index is asserted.
  for (genvar i = 0; i < M_COUNT; i++) begin : g_lane
    assign m_tvalid[i] = out_valid && (out_sel == SEL_W'(i));
  end

  // Skid transfers: int -> output, int -> temp, or temp -> output.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      temp_valid    <= 1'b0;
      ready_int_reg <= 1'b0;
      out_sel       <= '0;
      temp_sel      <= '0;
    end else begin
      ready_int_reg <= ready_int_early;
      if (ready_int_reg) begin
        if (sel_ready || !out_valid) begin
          out_valid <= int_valid;
          out_data  <= int_data;
          out_sel   <= int_sel;
        end else begin
          temp_valid <= int_valid;
          temp_data  <= int_data;
          temp_sel   <= int_sel;
        end
      end else if (sel_ready) begin
        out_valid  <= temp_valid;
        out_data   <= temp_data;
        out_sel    <= temp_sel;
        temp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axis_demux.sv
// Frame-aware AXI4-Stream demultiplexer. Destination and drop are latched at
// frame start and held until the tlast beat; beats leave through a registered
// skid stage so m_axis_tready never reaches s_axis_tready combinationally.
module axis_demux #(
  parameter int M_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = ((DATA_WIDTH + 7) / 8),
  parameter int ID_ENABLE   = 0,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_ENABLE = 0,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]            s_axis_tkeep,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  input  logic [ID_WIDTH-1:0]              s_axis_tid,
  input  logic [DEST_WIDTH-1:0]            s_axis_tdest,
  input  logic [USER_WIDTH-1:0]            s_axis_tuser,
  output logic [M_COUNT*DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [M_COUNT*KEEP_WIDTH-1:0]    m_axis_tkeep,
  output logic [M_COUNT-1:0]               m_axis_tvalid,
  input  logic [M_COUNT-1:0]               m_axis_tready,
  output logic [M_COUNT-1:0]               m_axis_tlast,
  output logic [M_COUNT*ID_WIDTH-1:0]      m_axis_tid,
  output logic [M_COUNT*DEST_WIDTH-1:0]    m_axis_tdest,
  output logic [M_COUNT*USER_WIDTH-1:0]    m_axis_tuser,
  input  logic                             enable,
  input  logic                             drop,
  input  logic [$clog2(M_COUNT)-1:0]       select
);

  localparam int CL_M_COUNT = $clog2(M_COUNT);
  localparam int PAYLOAD_W  = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
  // One extra bit so non-power-of-two port counts compare correctly.
  localparam logic [CL_M_COUNT:0] M_COUNT_W = M_COUNT[CL_M_COUNT:0];

  logic                  frame_reg, frame_next;
  logic                  drop_reg, drop_next;
  logic [CL_M_COUNT-1:0] select_reg, select_next;
  logic                  tready_next;
  logic                  ready_int_early;
  logic                  int_valid;

  logic [KEEP_WIDTH-1:0] s_keep, o_keep;
  logic [ID_WIDTH-1:0]   s_id, o_id;
  logic [DEST_WIDTH-1:0] s_dest, o_dest;
  logic [USER_WIDTH-1:0] s_user, o_user;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_last;
  logic [PAYLOAD_W-1:0]  int_data, out_data;

  // Disabled sideband fields are replaced by their fixed values on entry.
  assign s_keep = (KEEP_ENABLE != 0) ? s_axis_tkeep : '1;
  assign s_id   = (ID_ENABLE   != 0) ? s_axis_tid   : '0;
  assign s_dest = (DEST_ENABLE != 0) ? s_axis_tdest : '0;
  assign s_user = (USER_ENABLE != 0) ? s_axis_tuser : '0;

  assign int_data  = {s_axis_tdata, s_keep, s_axis_tlast, s_id, s_dest, s_user};
  assign int_valid = s_axis_tvalid && s_axis_tready && frame_reg && !drop_reg;

  // Frame tracking: latch routing at frame start, release on the tlast beat.
  always_comb begin
    frame_next  = frame_reg;
    select_next = select_reg;
    drop_next   = drop_reg;
    if (frame_reg) begin
      if (s_axis_tvalid && s_axis_tready && s_axis_tlast) frame_next = 1'b0;
    end else if (enable && s_axis_tvalid) begin
      frame_next  = 1'b1;
      select_next = select;
      drop_next   = drop || ({1'b0, select} >= M_COUNT_W);
    end
    tready_next = frame_next && (drop_next || ready_int_early);
  end

  // Control state and the registered s_axis_tready.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_reg     <= 1'b0;
      select_reg    <= '0;
      drop_reg      <= 1'b0;
      s_axis_tready <= 1'b0;
    end else begin
      frame_reg     <= frame_next;
      select_reg    <= select_next;
      drop_reg      <= drop_next;
      s_axis_tready <= tready_next;
    end
  end

  axis_demux_skid #(
    .M_COUNT   (M_COUNT),
    .PAYLOAD_W (PAYLOAD_W),
    .SEL_W     (CL_M_COUNT)
  ) u_skid (
    .clk             (clk),
    .rst             (rst),
    .int_data        (int_data),
    .int_sel         (select_reg),
    .int_valid       (int_valid),
    .ready_int_early (ready_int_early),
    .m_tready        (m_axis_tready),
    .m_tvalid        (m_axis_tvalid),
    .out_data        (out_data)
  );

  assign {o_data, o_keep, o_last, o_id, o_dest, o_user} = out_data;

  // Every lane carries the same payload; only tvalid distinguishes them.
  assign m_axis_tdata = {M_COUNT{o_data}};
  assign m_axis_tkeep = {M_COUNT{o_keep}};
  assign m_axis_tlast = {M_COUNT{o_last}};
  assign m_axis_tid   = {M_COUNT{o_id}};
  assign m_axis_tdest = {M_COUNT{o_dest}};
  assign m_axis_tuser = {M_COUNT{o_user}};

endmodule

// File: tb/tb_axis_demux.sv
// Directed bench for axis_demux with default parameters (4 ports, 8-bit data).
module tb_axis_demux;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_axis_tdata;
  logic [0:0]  s_axis_tkeep;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [7:0]  s_axis_tid, s_axis_tdest;
  logic [0:0]  s_axis_tuser;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep, m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic [31:0] m_axis_tid, m_axis_tdest;
  logic        enable, drop;
  logic [1:0]  select;

  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  port;
    logic        last;
    logic [7:0]  data;
  } beat_t;

  beat_t       rxq[$];
  logic [31:0] cyc = 0;
  int          oh_err = 0;
  int          n_chk = 0, n_fail = 0;
  logic [15:0] bp_pat = 16'b1001_0110_0011_1001;

  axis_demux dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid),
    .s_axis_tdest(s_axis_tdest), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
    .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser),
    .enable(enable), .drop(drop), .select(select)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: record every completed master transfer and one-hot errors.
  always @(negedge clk) begin
    if (!rst) begin
      if (!$onehot0(m_axis_tvalid)) oh_err <= oh_err + 1;
      for (int i = 0; i < 4; i++)
        if (m_axis_tvalid[i] && m_axis_tready[i])
          rxq.push_back('{cyc, 2'(i), m_axis_tlast[i], m_axis_tdata[i*8 +: 8]});
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Hold the current beat until accepted (bounded).
  task automatic wait_acc(input string tag);
    int g = 0;
    bit done = 0;
    while (!done && g < 100) begin
      @(negedge clk);
      done = s_axis_tready;
      @(posedge clk); #1;
      g++;
    end
    chk({tag, "_acc"}, 32'(done), 1);
  endtask

  // Send an n-beat frame base, base+1, ...; optional backpressure on port 3
  // and optional select/enable change after chg_at beats.
  task automatic send_frame(input string tag, input int n, input logic [7:0] base,
                            input bit bp, input int chg_at,
                            output int cycles, output int t_first);
    int k = 0;
    bit xfer, stall_prev = 0;
    cycles = 0; t_first = -1;
    s_axis_tvalid = 1; s_axis_tdata = base; s_axis_tlast = (n == 1);
    while (k < n && cycles < 400) begin
      @(negedge clk);
      if (stall_prev) chk({tag, "_rdy_drop"}, 32'(s_axis_tready), 0);
      xfer = s_axis_tready;
      stall_prev = xfer && !drop && |(m_axis_tvalid & ~m_axis_tready);
      if (xfer && t_first < 0) t_first = int'(cyc);
      @(posedge clk); #1;
      cycles++;
      if (bp) m_axis_tready[3] = bp_pat[cycles % 16];
      if (xfer) begin
        k++;
        s_axis_tdata = base + 8'(k);
        s_axis_tlast = (k == n - 1);
        if (k == chg_at) begin select = 2'd3; enable = 1'b0; end
      end
    end
    s_axis_tvalid = 0; s_axis_tlast = 0;
    chk({tag, "_sent"}, 32'(k), 32'(n));
  endtask

  // Compare beats received on one port against base, base+1, ... with tlast on the end.
  task automatic check_rx(input string tag, input int port, input int n, input logic [7:0] base);
    int got = 0;
    foreach (rxq[i]) begin
      if (int'(rxq[i].port) == port) begin
        if (got < n) begin
          chk({tag, "_data"}, 32'(rxq[i].data), 32'(base + 8'(got)));
          chk({tag, "_last"}, 32'(rxq[i].last), 32'(got == n - 1));
        end
        got++;
      end
    end
    chk({tag, "_cnt"}, 32'(got), 32'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int cy, tf;
    logic [31:0] lo0, fi1;
    rst = 1; s_axis_tvalid = 0; s_axis_tdata = 0; s_axis_tkeep = 1; s_axis_tlast = 0;
    s_axis_tid = 0; s_axis_tdest = 0; s_axis_tuser = 0;
    m_axis_tready = 4'hF; enable = 0; drop = 0; select = 0;
    @(posedge clk); @(negedge clk);
    chk("rst_s_tready", 32'(s_axis_tready), 0);
    chk("rst_m_tvalid", 32'(m_axis_tvalid), 0);
    @(posedge clk); #1 rst = 0;
    idle(2);

    // Route a 4-beat frame to port 2 with all outputs ready.
    rxq.delete(); enable = 1; select = 2;
    send_frame("route", 4, 8'h11, 0, -1, cy, tf);
    idle(4);
    chk("route_cycles", 32'(cy), 5);
    check_rx("route", 2, 4, 8'h11);
    if (rxq.size() > 0) chk("route_lat", rxq[0].cyc - 32'(tf), 1);
    foreach (rxq[k]) chk("route_cyc", rxq[k].cyc - rxq[0].cyc, 32'(k));

    // Dropped frame is consumed at full rate, then a normal frame to port 1.
    rxq.delete(); drop = 1; select = 0;
    send_frame("drop", 3, 8'h21, 0, -1, cy, tf);
    idle(4);
    chk("drop_cycles", 32'(cy), 4);
    chk("drop_none", 32'(rxq.size()), 0);
    drop = 0; select = 1;
    send_frame("after_drop", 3, 8'h31, 0, -1, cy, tf);
    idle(4);
    check_rx("after_drop", 1, 3, 8'h31);

    // Backpressure on port 3 for a 16-beat frame.
    rxq.delete(); select = 3;
    send_frame("bp", 16, 8'h00, 1, -1, cy, tf);
    m_axis_tready = 4'hF;
    idle(6);
    check_rx("bp", 3, 16, 8'h00);

    // select/enable change mid-frame is ignored; no new frame while disabled.
    rxq.delete(); select = 0; enable = 1;
    send_frame("mid", 5, 8'h41, 0, 2, cy, tf);
    s_axis_tvalid = 1; s_axis_tdata = 8'h50; s_axis_tlast = 1;
    repeat (4) begin @(negedge clk); chk("mid_hold", 32'(s_axis_tready), 0); end
    @(posedge clk); #1 enable = 1;
    send_frame("mid_next", 1, 8'h50, 0, -1, cy, tf);
    idle(4);
    check_rx("mid", 0, 5, 8'h41);
    check_rx("mid_next", 3, 1, 8'h50);

    // Port 0 stalled with two beats buffered, then a frame to port 1.
    rxq.delete(); select = 0; m_axis_tready = 4'b1110;
    send_frame("b2b0", 2, 8'h61, 0, -1, cy, tf);
    select = 1;
    fork
      send_frame("b2b1", 3, 8'h71, 0, -1, cy, tf);
      begin idle(6); m_axis_tready[0] = 1'b1; end
    join
    idle(4);
    check_rx("b2b0", 0, 2, 8'h61);
    check_rx("b2b1", 1, 3, 8'h71);
    lo0 = 0; fi1 = 32'hFFFF_FFFF;
    foreach (rxq[i]) begin
      if (rxq[i].port == 2'd0 && rxq[i].cyc > lo0) lo0 = rxq[i].cyc;
      if (rxq[i].port == 2'd1 && rxq[i].cyc < fi1) fi1 = rxq[i].cyc;
    end
    chk("b2b_order", 32'(fi1 > lo0), 1);

    // Reset mid-frame with the output stalled and two beats held.
    rxq.delete(); select = 2; m_axis_tready = 4'h0;
    s_axis_tvalid = 1; s_axis_tdata = 8'h81; s_axis_tlast = 0;
    wait_acc("rst_b1");
    s_axis_tdata = 8'h82;
    wait_acc("rst_b2");
    s_axis_tvalid = 0; rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst_mid_m_tvalid", 32'(m_axis_tvalid), 0);
    chk("rst_mid_s_tready", 32'(s_axis_tready), 0);
    @(posedge clk); #1 m_axis_tready = 4'hF;
    idle(4);
    chk("rst_discard", 32'(rxq.size()), 0);
    select = 1;
    send_frame("post_rst", 2, 8'h91, 0, -1, cy, tf);
    idle(4);
    check_rx("post_rst", 1, 2, 8'h91);

    chk("onehot", 32'(oh_err), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
